// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES pad poller: FSM states, button bit
// positions, and default pad timing for a 27 MHz system clock.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_e;

  // Bit positions in o_buttons, which is also the order the 4021 shifts them out.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int DEF_CLK_HZ       = 27_000_000;
  localparam int DEF_POLL_HZ      = 120;
  localparam int DEF_LATCH_CYCLES = 324;
  localparam int DEF_HALF_CYCLES  = 162;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_pad_tick_gen.sv
// Poll-rate tick: counts 0..CLK_HZ/POLL_HZ-1 and pulses o_tick for one cycle
// on the terminal count. Free-running; only i_rst stops it.
module nes_pad_tick_gen
  import nes_pad_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int POLL_HZ = DEF_POLL_HZ
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int POLL_DIV = CLK_HZ / POLL_HZ;
  localparam int CNT_W    = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = o_tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nes_pad_poller.sv
// NES controller poller: drives the 4021 latch/clock, samples serial data and
// publishes the 8 buttons with a valid strobe. Define NES_PAD_DOUBLE_READ_EN to
// read each frame twice and publish only when both reads agree.
module nes_pad_poller
  import nes_pad_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int POLL_HZ      = DEF_POLL_HZ,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEF_HALF_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_poll_en,
  input  logic       i_joy_data,
  output logic       o_joy_latch,
  output logic       o_joy_clk,
  output logic [7:0] o_buttons,
  output logic       o_valid,
  output logic       o_busy
);

  localparam int PH_W = $clog2(max_int(LATCH_CYCLES, HALF_CYCLES));
  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_CYCLES - 1);
  localparam logic [2:0]      IDX_LAST   = 3'(BTN_RIGHT);

  logic tick;

  nes_pad_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .POLL_HZ (POLL_HZ)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      sync_q, sync_d;
  logic            latch_q, latch_d;
  logic            jclk_q, jclk_d;
  logic [7:0]      buttons_q, buttons_d;
  logic            valid_q, valid_d;
`ifdef NES_PAD_DOUBLE_READ_EN
  logic            pass_q, pass_d;
  logic [7:0]      first_q, first_d;
`endif

  // Pad data is active-low; invert after the synchroniser so shift is active-high.
  logic sample;
  assign sample = ~sync_q[1];

  assign o_joy_latch = latch_q;
  assign o_joy_clk   = jclk_q;
  assign o_buttons   = buttons_q;
  assign o_valid     = valid_q;
  assign o_busy      = (state_q != IDLE);

  always_comb begin
    // NOTE: every _d starts from its _q (strobes from 0) so no branch can infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    sync_d    = {sync_q[0], i_joy_data};
    latch_d   = 1'b0;
    jclk_d    = 1'b0;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
`ifdef NES_PAD_DOUBLE_READ_EN
    pass_d    = pass_q;
    first_d   = first_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Ticks arriving mid-frame or while disabled are simply dropped.
        if (tick && i_poll_en) begin
          state_d = LATCH;
          phase_d = '0;
          latch_d = 1'b1;
        end
      end
      LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = LOW;
          phase_d = '0;
          idx_d   = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
          latch_d = 1'b1;
        end
      end
      LOW: begin
        if (phase_q == HALF_LAST) begin
          shift_d[idx_q] = sample;
          state_d        = HIGH;
          phase_d        = '0;
          jclk_d         = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      HIGH: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOW;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
          jclk_d  = 1'b1;
        end
      end
      DONE: begin
`ifdef NES_PAD_DOUBLE_READ_EN
        if (!pass_q) begin
          pass_d  = 1'b1;
          first_d = shift_q;
          state_d = LATCH;
          phase_d = '0;
          latch_d = 1'b1;
        end else begin
          pass_d  = 1'b0;
          state_d = IDLE;
          if (shift_q == first_q) begin
            buttons_d = shift_q;
            valid_d   = 1'b1;
          end
        end
`else
        buttons_d = shift_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the shift register is cleared too, so a frame cut short by reset leaves no stale bits.
      state_q   <= IDLE;
      phase_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      sync_q    <= 2'b11;
      latch_q   <= 1'b0;
      jclk_q    <= 1'b0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
`ifdef NES_PAD_DOUBLE_READ_EN
      pass_q    <= 1'b0;
      first_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      sync_q    <= sync_d;
      latch_q   <= latch_d;
      jclk_q    <= jclk_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
`ifdef NES_PAD_DOUBLE_READ_EN
      pass_q    <= pass_d;
      first_q   <= first_d;
`endif
    end
  end

endmodule

// File: tb/tb_nes_pad_poller.sv
// Self-checking bench for nes_pad_poller: behavioural 4021 pad model plus
// per-frame expected waveforms derived from the latch/half-period timing rules.
module tb_nes_pad_poller;

  localparam int CLK_HZ       = 1000;
  localparam int POLL_HZ      = 1;
  localparam int LATCH_CYCLES = 4;
  localparam int HALF_CYCLES  = 2;
  localparam int POLL_DIV     = CLK_HZ / POLL_HZ;
  localparam int FRAME_LEN    = LATCH_CYCLES + 16 * HALF_CYCLES + 1;
`ifdef NES_PAD_DOUBLE_READ_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int VALID_OFF  = PASSES * FRAME_LEN;
  localparam int WAIT_BOUND = POLL_DIV + 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_en = 1'b0;
  logic       joy_data;
  logic       joy_latch, joy_clk, valid, busy;
  logic [7:0] buttons;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_btn = 8'h00;
  bit         tie_high = 1'b0;
  logic [7:0] pad_sr = 8'h00;
  logic [7:0] pad_q[$];

  always #5 clk = ~clk;

  nes_pad_poller #(
    .CLK_HZ       (CLK_HZ),
    .POLL_HZ      (POLL_HZ),
    .LATCH_CYCLES (LATCH_CYCLES),
    .HALF_CYCLES  (HALF_CYCLES)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_poll_en   (poll_en),
    .i_joy_data  (joy_data),
    .o_joy_latch (joy_latch),
    .o_joy_clk   (joy_clk),
    .o_buttons   (buttons),
    .o_valid     (valid),
    .o_busy      (busy)
  );

  // 4021 model: parallel load on latch, shift toward the output on each clk rise.
  always @(posedge joy_latch or posedge joy_clk) begin
    if (joy_latch) begin
      if (pad_q.size() > 0) pad_sr <= pad_q.pop_front();
      else                  pad_sr <= 8'h00;
    end else begin
      pad_sr <= {1'b0, pad_sr[7:1]};
    end
  end
  assign joy_data = tie_high | ~pad_sr[0];

  initial begin
    #(100_000 * 10);
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_latch(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < WAIT_BOUND) begin
      step();
      n++;
      if (joy_latch === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Checks one whole frame (all passes) starting at the first cycle latch is high.
  task automatic frame_body(input logic [7:0] exp_btn, input bit exp_valid,
                            input int drop_at, input string tag);
    int   bad_latch = 0, bad_clk = 0, bad_busy = 0, bad_valid = 0, bad_btn = 0;
    int   pulses = 0;
    int   p;
    bit   in_frame, e_latch, e_clk, e_busy, e_valid;
    logic prev_clk = 1'b0;
    logic [7:0] e_btn;
    for (int o = 0; o <= VALID_OFF + 1; o++) begin
      if (o > 0) step();
      if (o == drop_at) poll_en = 1'b0;
      p        = o % FRAME_LEN;
      in_frame = (o < VALID_OFF);
      e_latch  = in_frame && (p < LATCH_CYCLES);
      e_clk    = in_frame && (p >= LATCH_CYCLES) && (p < LATCH_CYCLES + 16 * HALF_CYCLES)
                 && (((p - LATCH_CYCLES) / HALF_CYCLES) % 2 == 1);
      e_busy   = in_frame;
      e_valid  = exp_valid && (o == VALID_OFF);
      e_btn    = (exp_valid && o >= VALID_OFF) ? exp_btn : model_btn;
      if (joy_latch !== e_latch) bad_latch++;
      if (joy_clk   !== e_clk)   bad_clk++;
      if (busy      !== e_busy)  bad_busy++;
      if (valid     !== e_valid) bad_valid++;
      if (buttons   !== e_btn)   bad_btn++;
      if (joy_clk === 1'b1 && prev_clk === 1'b0) pulses++;
      prev_clk = joy_clk;
    end
    if (exp_valid) model_btn = exp_btn;

    checks++;
    if (bad_latch !== 0) begin
      errors++;
      $display("FAIL %s latch_wave: %0d cycles wrong, required 0", tag, bad_latch);
    end
    checks++;
    if (bad_clk !== 0) begin
      errors++;
      $display("FAIL %s clk_wave: %0d cycles wrong, required 0", tag, bad_clk);
    end
    checks++;
    if (pulses !== 8 * PASSES) begin
      errors++;
      $display("FAIL %s clk_pulses: got %0d, required %0d", tag, pulses, 8 * PASSES);
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++;
      $display("FAIL %s busy_wave: %0d cycles wrong, required 0", tag, bad_busy);
    end
    checks++;
    if (bad_valid !== 0) begin
      errors++;
      $display("FAIL %s valid_wave: %0d cycles wrong, required 0 (valid expected=%0b)",
               tag, bad_valid, exp_valid);
    end
    checks++;
    if (bad_btn !== 0 || buttons !== model_btn) begin
      errors++;
      $display("FAIL %s buttons: got 0x%02h (%0d cycles wrong), required 0x%02h",
               tag, buttons, bad_btn, model_btn);
    end
  endtask

  // Loads the pad with v1 (and v2 for the second pass), waits for the frame, checks it.
  task automatic run_frame(input logic [7:0] v1, input logic [7:0] v2, input int drop_at,
                           input string tag, output int wait_n);
    logic [7:0] s1, s2;
    bit         ok, ev;
    pad_q.delete();
    pad_q.push_back(v1);
    if (PASSES == 2) pad_q.push_back(v2);
    s1 = tie_high ? 8'h00 : v1;
    s2 = tie_high ? 8'h00 : v2;
    ev = (PASSES == 1) || (s1 == s2);
    wait_latch(wait_n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s latch_timeout: no latch within %0d cycles, required one", tag, WAIT_BOUND);
      return;
    end
    frame_body(s1, ev, drop_at, tag);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    poll_en = 1'b1;
    repeat (5) step();
    checks++;
    if (joy_latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b, required 0", joy_latch); end
    checks++;
    if (joy_clk !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b, required 0", joy_clk); end
    checks++;
    if (buttons !== 8'h00) begin errors++; $display("FAIL reset_buttons: got 0x%02h, required 0x00", buttons); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    int n;
    run_frame(8'hA5, 8'hA5, -1, "pad_a5", n);
    checks++;
    if (n !== POLL_DIV) begin
      errors++;
      $display("FAIL first_latch: rose at cycle %0d after release, required %0d", n, POLL_DIV);
    end
  endtask

  task automatic test_random_frames();
    int         n;
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      run_frame(v, v, -1, $sformatf("rand%0d", i), n);
    end
  endtask

  task automatic test_tied_high();
    int         n;
    logic [7:0] v;
    tie_high = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v = 8'($urandom) | 8'h01;
      run_frame(v, v, -1, $sformatf("tied%0d", i), n);
    end
    tie_high = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int         n, pulses;
    bit         ok;
    logic       prev_clk;
    logic [7:0] v;
    pad_q.delete();
    pad_q.push_back(8'h3C);
    pad_q.push_back(8'h3C);
    wait_latch(n, ok);
    pulses   = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < 100 && pulses < 4; i++) begin
      step();
      if (joy_clk === 1'b1 && prev_clk === 1'b0) pulses++;
      prev_clk = joy_clk;
    end
    checks++;
    if (!ok || pulses !== 4) begin
      errors++;
      $display("FAIL rst_mid_reach: latch_seen=%0b pulses=%0d, required 1 and 4", ok, pulses);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_btn = 8'h00;
    checks++;
    if ({joy_latch, joy_clk, valid, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_ctrl: latch/clk/valid/busy=%b, required 0000",
               {joy_latch, joy_clk, valid, busy});
    end
    checks++;
    if (buttons !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_buttons: got 0x%02h, required 0x00", buttons);
    end
    v = 8'($urandom);
    run_frame(v, v, -1, "after_rst", n);
    checks++;
    if (n !== POLL_DIV) begin
      errors++;
      $display("FAIL after_rst_latch: rose at cycle %0d after release, required %0d", n, POLL_DIV);
    end
  endtask

  task automatic test_poll_en_drop();
    int         n, latch_cycles;
    logic [7:0] v;
    v = 8'($urandom);
    run_frame(v, v, 10, "en_drop", n);
    latch_cycles = 0;
    for (int i = 0; i < 2 * POLL_DIV + 100; i++) begin
      step();
      if (joy_latch !== 1'b0 || busy !== 1'b0) latch_cycles++;
    end
    checks++;
    if (latch_cycles !== 0) begin
      errors++;
      $display("FAIL en_drop_idle: %0d active cycles after disable, required 0", latch_cycles);
    end
  endtask

`ifdef NES_PAD_DOUBLE_READ_EN
  task automatic test_double_read();
    int n;
    poll_en = 1'b1;
    run_frame(8'h0F, 8'h1F, -1, "dbl_mismatch", n);
    run_frame(8'h1F, 8'h1F, -1, "dbl_match", n);
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_random_frames();
    test_tied_high();
    test_reset_mid_frame();
`ifdef NES_PAD_DOUBLE_READ_EN
    test_double_read();
`endif
    test_poll_en_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
